// File: rtl/coin_acceptor.sv
// Coin/button front end: sync, debounce, serialize and pace B1/B2/B3 pulses for the vending FSM.
// Optional pulse statistics counter (total_cnt) is enabled with `define COIN_ACCEPTOR_STATS_EN.
module coin_acceptor #(
  parameter int DEB_CYCLES = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int GAP_CYCLES = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_b1,
  input  logic raw_b2,
  input  logic raw_b3,
  input  logic clr_ovf,
  output logic B1,
  output logic B2,
  output logic B3,
  output logic ovf,
`ifdef COIN_ACCEPTOR_STATS_EN
  output logic [7:0] total_cnt,
`endif
  output logic [$clog2(FIFO_DEPTH):0] fifo_cnt
);

  // state   | meaning
  // IDLE_LO | line accepted low
  // ARM_HI  | line seen high, counting stable highs
  // HELD_HI | line accepted high, event already raised
  // ARM_LO  | line seen low while held, counting stable lows
  localparam logic [1:0] IDLE_LO = 2'd0;
  localparam logic [1:0] ARM_HI  = 2'd1;
  localparam logic [1:0] HELD_HI = 2'd2;
  localparam logic [1:0] ARM_LO  = 2'd3;

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [7:0] DEB_LAST = 8'(DEB_CYCLES - 1);
  localparam logic [3:0] GAP_LOAD = 4'(GAP_CYCLES);

  logic [2:0] raw, sync1, sync2, pend, clr;
  logic [1:0] st [3];
  logic [7:0] cnt [3];
  logic       push_req, push_ok, pop, full, drop;
  logic [1:0] push_code, pop_code;
  logic [1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [3:0] gap;

  assign raw = {raw_b3, raw_b2, raw_b1};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Pending bit is raised once per accepted rising level and cleared when the enqueue stage takes it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend <= '0;
      for (int i = 0; i < 3; i++) begin
        st[i]  <= IDLE_LO;
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        pend[i] <= pend[i] & ~clr[i];
        case (st[i])
          IDLE_LO:
            if (sync2[i]) begin
              if (DEB_CYCLES <= 1) begin
                st[i]   <= HELD_HI;
                pend[i] <= 1'b1;
              end else begin
                st[i]  <= ARM_HI;
                cnt[i] <= 8'd1;
              end
            end
          ARM_HI:
            if (!sync2[i]) begin
              st[i] <= IDLE_LO;
            end else if (cnt[i] >= DEB_LAST) begin
              st[i]   <= HELD_HI;
              pend[i] <= 1'b1;
            end else begin
              cnt[i] <= cnt[i] + 8'd1;
            end
          HELD_HI:
            if (!sync2[i]) begin
              if (DEB_CYCLES <= 1) begin
                st[i] <= IDLE_LO;
              end else begin
                st[i]  <= ARM_LO;
                cnt[i] <= 8'd1;
              end
            end
          ARM_LO:
            if (sync2[i]) begin
              st[i] <= HELD_HI;
            end else if (cnt[i] >= DEB_LAST) begin
              st[i] <= IDLE_LO;
            end else begin
              cnt[i] <= cnt[i] + 8'd1;
            end
          default: st[i] <= IDLE_LO;
        endcase
      end
    end
  end

  always_comb begin
    push_req  = |pend;
    push_code = 2'd1;
    clr       = 3'b000;
    if (pend[2]) begin
      push_code = 2'd3;
      clr       = 3'b100;
    end else if (pend[1]) begin
      push_code = 2'd2;
      clr       = 3'b010;
    end else if (pend[0]) begin
      push_code = 2'd1;
      clr       = 3'b001;
    end
  end

  // A same-cycle pop frees a slot, so a push into a full FIFO still lands.
  assign full     = (fifo_cnt == CW'(FIFO_DEPTH));
  assign pop      = (fifo_cnt != '0) && (gap == 4'd0);
  assign push_ok  = push_req && (!full || pop);
  assign drop     = push_req && full && !pop;
  assign pop_code = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_code;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      gap      <= '0;
      ovf      <= 1'b0;
      B1       <= 1'b0;
      B2       <= 1'b0;
      B3       <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
      if (pop)              gap <= GAP_LOAD;
      else if (gap != 4'd0) gap <= gap - 4'd1;
      if (clr_ovf)   ovf <= 1'b0;
      else if (drop) ovf <= 1'b1;
      B1 <= pop && (pop_code == 2'd1);
      B2 <= pop && (pop_code == 2'd2);
      B3 <= pop && (pop_code == 2'd3);
    end
  end

`ifdef COIN_ACCEPTOR_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                            total_cnt <= '0;
    else if (pop && (total_cnt != 8'hFF)) total_cnt <= total_cnt + 8'd1;
  end
`endif

endmodule
